// File: rtl/lab2_proc_mem_arb.sv
// Round-robin arbiter sharing one memory between imem and dmem ports.
// Responses return in order, steered by a FIFO of requester IDs.
module lab2_proc_mem_arb #(
  parameter int p_req_nbits    = 77,
  parameter int p_resp_nbits   = 47,
  parameter int p_max_inflight = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req0_val,
  output logic                                  req0_rdy,
  input  logic [p_req_nbits-1:0]                req0_msg,
  input  logic                                  req1_val,
  output logic                                  req1_rdy,
  input  logic [p_req_nbits-1:0]                req1_msg,
  output logic                                  memreq_val,
  input  logic                                  memreq_rdy,
  output logic [p_req_nbits-1:0]                memreq_msg,
  input  logic                                  memresp_val,
  output logic                                  memresp_rdy,
  input  logic [p_resp_nbits-1:0]               memresp_msg,
  output logic                                  resp0_val,
  input  logic                                  resp0_rdy,
  output logic [p_resp_nbits-1:0]               resp0_msg,
  output logic                                  resp1_val,
  input  logic                                  resp1_rdy,
  output logic [p_resp_nbits-1:0]               resp1_msg,
  output logic [$clog2(p_max_inflight+1)-1:0]   inflight
);

  localparam int CW = $clog2(p_max_inflight + 1);
  localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam logic [PW-1:0] LAST = PW'(p_max_inflight - 1);

  logic                      prio;
  logic [p_max_inflight-1:0] ids;
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;

  logic full;
  logic empty;
  logic gnt;
  logic head_id;
  logic push;
  logic pop;

  assign full  = (inflight == CW'(p_max_inflight));
  assign empty = (inflight == '0);

  // With no request pending gnt is 0, so memreq_msg falls back to req0_msg.
  assign gnt = (req0_val & req1_val) ? prio : req1_val;

  assign memreq_val = (req0_val | req1_val) & ~full;
  assign memreq_msg = gnt ? req1_msg : req0_msg;
  assign req0_rdy   = req0_val & ~gnt & memreq_rdy & ~full;
  assign req1_rdy   = req1_val &  gnt & memreq_rdy & ~full;
  assign push       = memreq_val & memreq_rdy;

  assign head_id     = ids[head];
  assign resp0_val   = memresp_val & ~empty & ~head_id;
  assign resp1_val   = memresp_val & ~empty &  head_id;
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign memresp_rdy = ~empty & (head_id ? resp1_rdy : resp0_rdy);
  assign pop         = memresp_val & memresp_rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio     <= 1'b1;
      ids      <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= '0;
    end else begin
      if (push) begin
        ids[tail] <= gnt;
        tail      <= (tail == LAST) ? '0 : tail + 1'b1;
        prio      <= ~gnt;
      end
      if (pop) begin
        head <= (head == LAST) ? '0 : head + 1'b1;
      end
      unique case (1'b1)
        push & ~pop: inflight <= inflight + 1'b1;
        pop & ~push: inflight <= inflight - 1'b1;
        default:     inflight <= inflight;
      endcase
    end
  end

endmodule

// File: doc/lab2_proc_mem_arb.md
# lab2_proc_mem_arb

Two-requester memory arbiter that lets the pipelined processor's instruction-fetch port (requester 0) and data port (requester 1) share a single-ported memory. Requests are granted round-robin, and up to `p_max_inflight` granted requests may be outstanding. Responses are steered back to the correct requester by an in-order tracking FIFO of requester IDs. The block sits between the processor's imem/dmem val/rdy ports and the single memory interface; it adds no latency on either path.

## Interface
- `p_req_nbits`, 77: width of a memory request message (mem_req_4B_t).
- `p_resp_nbits`, 47: width of a memory response message (mem_resp_4B_t).
- `p_max_inflight`, 4: tracking FIFO depth; must be ≥1.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset. State clears on a rising `clk` edge when `reset`==0.
- `req0_val` in 1, `req0_rdy` out 1, `req0_msg` in p_req_nbits: imem request.
- `req1_val` in 1, `req1_rdy` out 1, `req1_msg` in p_req_nbits: dmem request.
- `memreq_val` out 1, `memreq_rdy` in 1, `memreq_msg` out p_req_nbits: shared memory request.
- `memresp_val` in 1, `memresp_rdy` out 1, `memresp_msg` in p_resp_nbits: shared memory response.
- `resp0_val` out 1, `resp0_rdy` in 1, `resp0_msg` out p_resp_nbits: imem response.
- `resp1_val` out 1, `resp1_rdy` in 1, `resp1_msg` out p_resp_nbits: dmem response.
- `inflight` out $clog2(p_max_inflight+1): number of outstanding requests.

## Operation
- **Handshakes.** All ports are val/rdy. A transfer fires when val && rdy on a rising edge. A val signal never depends combinationally on its own rdy.
- **State.**
  - `prio` (1 bit): the requester with priority.
  - Tracking FIFO: `p_max_inflight` entries of 1-bit IDs, with head/tail pointers that wrap modulo depth.
  - `inflight` count.
- **Request arbitration.**
  - `full` = (`inflight` == `p_max_inflight`).
  - If both vals are high, the grant goes to `prio`. Otherwise it goes to whichever val is high.
  - `memreq_val` = (`req0_val` | `req1_val`) & !`full`.
  - `memreq_msg` = msg of the granted requester. When no val is high, `memreq_msg` = `req0_msg`.
  - `reqN_rdy` = granted(N) & `memreq_rdy` & !`full`. The ungranted requester sees rdy=0.
- **Request fire.**
  - Push the granted ID at the tail.
  - Set `prio` to the other requester, i.e. !granted.
  - `prio` changes only on a fire; a stalled grant keeps its priority.
- **Response routing.**
  - `head_id` = ID at the FIFO head.
  - `respN_val` = `memresp_val` & !empty & (`head_id` == N).
  - `respN_msg` = `memresp_msg` for both N.
  - `memresp_rdy` = !empty & `resp[head_id]_rdy`.
  - A response fire pops the head.
- **Empty FIFO.** `memresp_rdy`=0 and both `respN_val`=0. A response arriving with nothing outstanding is never accepted.
- **Full FIFO.** Request push is blocked even if a pop fires in the same cycle; no bypass.
- **Push and pop in the same cycle** (not full): both pointers advance and `inflight` is unchanged.
- **Count.** `inflight` += push − pop. It never exceeds `p_max_inflight` and never underflows.
- **Ordering.** Responses are in order, which relies on the memory being in-order. Per-requester order is preserved.
- **Reset** (`reset`==0 at an edge, including mid-operation):
  - `prio`=1 (dmem first), pointers=0, `inflight`=0.
  - Outstanding responses are forgotten; memory is reset together with this block.

## Timing
- Request and response paths are purely combinational, with zero added cycles. Throughput is one request and one response per cycle.
- `prio`, pointers and `inflight` update on the rising `clk` edge after a fire.
- Outputs after reset:
  - `memreq_val`=0 and `req*_rdy`=0 unless a val is asserted.
  - `memresp_rdy`=0, `resp*_val`=0, `inflight`=0.
- An outstanding request blocks nothing: a new grant may fire in the same cycle as a response.
- While `reset`==0, outputs are still computed from the current state. Whether a transfer fires during reset is don't-care.

## Test plan
- **Single imem.** `req0_val`=1, msg=addr 0x200 read, `memreq_rdy`=1 → `memreq_msg`=`req0_msg` the same cycle, `inflight`=1. Then a response with data 0x13 → `resp0_val`=1 with data 0x13, `resp1_val`=0, `inflight`=0.
- **Contention round-robin.** Both vals held for 4 cycles, `memreq_rdy`=1, responses held off → grant order 1,0,1,0 starting from reset. FIFO IDs are 1,0,1,0 and `inflight`=4 (full).
- **Full back-pressure.** `inflight`=4, `req0_val`=1 → `memreq_val`=0 and `req0_rdy`=0. One response pops with a request pending the same cycle → no push that cycle, `inflight`=3. The next cycle the grant fires.
- **Response back-pressure.** Head ID=1 and `resp1_rdy`=0 → `memresp_rdy`=0 and the head is held. Raising `resp1_rdy` → pop, after which the next ID=0 routes to `resp0`.
- **Empty / stray response.** `inflight`=0 with `memresp_val`=1 → `memresp_rdy`=0 and both `resp*_val`=0 for 3 cycles.
- **Reset mid-operation.** `inflight`=3, drive `reset`=0 for one edge → `inflight`=0, `prio`=1. With both vals high afterwards, the first grant goes to requester 1.
